unified_mem_arbiter: RTL and testbench

//  Shares one single-port, synchronous-read 32-bit memory between the instruction-fetch

---
 rtl/femto_mem_pkg.sv | 16 +
 rtl/mem_arb_starve_cnt.sv | 28 ++
 rtl/unified_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/femto_mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory arbiter.
package femto_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_e;

  // Byte address to word address; callers slice the low ADDR_W bits.
  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive fetch denials; at_max forces the next fetch grant.
module mem_arb_starve_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned W = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  assign at_max = (r_cnt == W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !at_max) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous-read memory between fetch and data requesters.
// Data has priority; a starvation guard bounds how long fetch can be denied.
module unified_mem_arbiter
  import femto_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  owner_e      r_owner;
  owner_e      w_owner_nxt;
  logic        r_err_q;
  logic        w_err_nxt;
  logic        w_at_max;
  logic        w_if_gnt;
  logic        w_d_gnt;
  logic        w_starve_inc;
  logic [29:0] w_if_word;
  logic [29:0] w_d_word;
  logic        w_if_inr;
  logic        w_d_inr;

  assign w_if_word = word_of(if_addr);
  assign w_d_word  = word_of(d_addr);
  assign w_if_inr  = ((w_if_word >> ADDR_W) == '0);
  assign w_d_inr   = ((w_d_word >> ADDR_W) == '0);

  always_comb begin
    w_d_gnt  = d_req && !(if_req && w_at_max);
    w_if_gnt = if_req && !w_d_gnt;
  end

  assign w_starve_inc = if_req && !w_if_gnt;

  mem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_starve_inc),
    .clr    (!w_starve_inc),
    .at_max (w_at_max)
  );

  always_comb begin
    w_owner_nxt = OWN_NONE;
    w_err_nxt   = 1'b0;
    if (w_d_gnt) begin
      w_owner_nxt = d_we ? OWN_DWR : OWN_DRD;
      w_err_nxt   = !w_d_inr;
    end else if (w_if_gnt) begin
      w_owner_nxt = OWN_IF;
      w_err_nxt   = !w_if_inr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
      r_err_q <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_err_q <= w_err_nxt;
    end
  end

  // Combinational outputs are gated by rst_n so nothing leaks while reset is held.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = w_d_gnt ? w_d_word[ADDR_W-1:0] : w_if_word[ADDR_W-1:0];
    mem_wdata = d_wdata;
    if_valid  = 1'b0;
    if_rdata  = '0;
    if_err    = 1'b0;
    d_valid   = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    if (rst_n) begin
      if_gnt = w_if_gnt;
      d_gnt  = w_d_gnt;
      if (w_d_gnt) begin
        mem_en = w_d_inr;
        mem_we = (d_we && w_d_inr) ? d_be : 4'b0000;
      end else if (w_if_gnt) begin
        mem_en = w_if_inr;
      end
      unique case (r_owner)
        OWN_IF: begin
          if_valid = 1'b1;
          if_err   = r_err_q;
          if_rdata = r_err_q ? '0 : mem_rdata;
        end
        OWN_DRD: begin
          d_valid = 1'b1;
          d_err   = r_err_q;
          d_rdata = r_err_q ? '0 : mem_rdata;
        end
        OWN_DWR: begin
          d_valid = 1'b1;
          d_err   = r_err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with a behavioural memory.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        bd_we;
  logic [5:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;

  unified_mem_arbiter #(
    .ADDR_W     (6),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_be      (d_be),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_en) begin
      if (mem_we == 4'b0000) begin
        mem_rdata <= mem[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] v);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = v;
    tick();
    bd_we   = 1'b0;
  endtask

  logic [31:0] fetch_exp [3];

  initial begin
    fetch_exp[0] = 32'h00000093;
    fetch_exp[1] = 32'h00108113;
    fetch_exp[2] = 32'h00210193;
    rst_n   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_be    = '0;
    d_wdata = '0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    mem_rdata = '0;

    for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);
    preload(6'd0, 32'h00000093);
    preload(6'd1, 32'h00108113);
    preload(6'd2, 32'h00210193);
    preload(6'd3, 32'hDEADBEEF);
    preload(6'd4, 32'hAAAAAAAA);

    // Reset held with requests active: no grants or enables escape.
    if_req = 1'b1;
    d_req  = 1'b1;
    #1;
    check("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    check("rst_d_gnt",  {31'b0, d_gnt},  32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    if_req = 1'b0;
    d_req  = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset mid-access: grant then reset before the response edge.
    if_req  = 1'b1;
    if_addr = 32'h0;
    #1;
    check("mid_if_gnt", {31'b0, if_gnt}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_gnt_forced", {31'b0, if_gnt}, 32'd0);
    if_req = 1'b0;
    tick();
    check("mid_no_valid", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_outs",
          {24'b0, if_gnt, if_valid, if_err, d_gnt, d_valid, d_err, mem_en, |mem_we}, 32'd0);
    check("post_rst_if_rdata", if_rdata, 32'd0);
    check("post_rst_d_rdata",  d_rdata,  32'd0);

    // Fetch only, back-to-back.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        check("fetch_valid", {31'b0, if_valid}, 32'd1);
        check("fetch_rdata", if_rdata, fetch_exp[i-1]);
        check("fetch_err",   {31'b0, if_err}, 32'd0);
      end
      if (i < 3) begin
        if_req  = 1'b1;
        if_addr = 32'(4 * i);
        #1;
        check("fetch_gnt",  {31'b0, if_gnt}, 32'd1);
        check("fetch_addr", {26'b0, mem_addr}, 32'(i));
        tick();
      end else begin
        if_req = 1'b0;
        tick();
        check("fetch_idle", {31'b0, if_valid}, 32'd0);
      end
    end

    // Conflict: data first, fetch once data drops.
    if_req  = 1'b1;
    if_addr = 32'h0;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0C;
    #1;
    check("conf_d_gnt",  {31'b0, d_gnt},  32'd1);
    check("conf_if_gnt", {31'b0, if_gnt}, 32'd0);
    tick();
    check("conf_d_valid", {31'b0, d_valid}, 32'd1);
    check("conf_d_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0;
    #1;
    check("conf_if_gnt2", {31'b0, if_gnt}, 32'd1);
    tick();
    check("conf_if_rdata", if_rdata, 32'h00000093);
    if_req = 1'b0;
    tick();

    // Starvation: fetch forced after four denials, then four more.
    if_req = 1'b1;
    d_req  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1;
      check("starve_if_gnt", {31'b0, if_gnt}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
      check("starve_d_gnt",  {31'b0, d_gnt},  (i == 4 || i == 9) ? 32'd0 : 32'd1);
      tick();
      if (i == 4 || i == 9) begin
        check("starve_if_rdata", if_rdata, 32'h00000093);
        check("starve_d_quiet", {31'b0, d_valid}, 32'd0);
      end else begin
        check("starve_d_rdata", d_rdata, 32'hDEADBEEF);
        check("starve_if_quiet", {31'b0, if_valid}, 32'd0);
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();

    // Partial store then load back.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h10;
    d_be    = 4'b0011;
    d_wdata = 32'h11223344;
    #1;
    check("st_gnt",    {31'b0, d_gnt}, 32'd1);
    check("st_mem_en", {31'b0, mem_en}, 32'd1);
    check("st_mem_we", {28'b0, mem_we}, 32'h3);
    check("st_addr",   {26'b0, mem_addr}, 32'd4);
    check("st_wdata",  mem_wdata, 32'h11223344);
    tick();
    check("st_ack",   {31'b0, d_valid}, 32'd1);
    check("st_rdata", d_rdata, 32'd0);
    check("st_err",   {31'b0, d_err}, 32'd0);
    d_we = 1'b0;
    #1;
    check("ld_mem_we", {28'b0, mem_we}, 32'd0);
    tick();
    check("ld_rdata", d_rdata, 32'hAAAA3344);

    // Out-of-range load and store.
    d_addr = 32'h100;
    #1;
    check("oor_ld_gnt",    {31'b0, d_gnt}, 32'd1);
    check("oor_ld_mem_en", {31'b0, mem_en}, 32'd0);
    tick();
    check("oor_ld_valid", {31'b0, d_valid}, 32'd1);
    check("oor_ld_err",   {31'b0, d_err}, 32'd1);
    check("oor_ld_rdata", d_rdata, 32'd0);
    d_we = 1'b1;
    d_be = 4'b1111;
    #1;
    check("oor_st_mem_we", {28'b0, mem_we}, 32'd0);
    check("oor_st_mem_en", {31'b0, mem_en}, 32'd0);
    tick();
    check("oor_st_err", {31'b0, d_err}, 32'd1);
    d_req = 1'b0;
    d_we  = 1'b0;
    d_addr = 32'h10;
    tick();
    check("oor_clear_err", {31'b0, d_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
